// File: rtl/pmu_pkg.sv
// Shared definitions for the PMU request path: mode-vector field encodings, reserved
// vectors and the request FSM state type, common to the controller and power manager.
package pmu_pkg;

    typedef enum logic [1:0] {
        ClkSrcClk     = 2'b00,
        ClkSrcPll     = 2'b01,
        ClkSrcDiv     = 2'b10,
        ClkSrcInvalid = 2'b11
    } clk_src_e;

    typedef enum logic [1:0] {
        DivFr1     = 2'b00,
        DivFr2     = 2'b01,
        DivFr3     = 2'b10,
        DivInvalid = 2'b11
    } div_sel_e;

    typedef struct packed {
        div_sel_e div_sel;
        clk_src_e clock3;
        clk_src_e clock2;
        clk_src_e clock1;
    } pmu_vec_t;

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StReq  = 2'b01,
        StDone = 2'b10
    } pmu_state_e;

    localparam logic [7:0] RESET_MODE = 8'h20;
    localparam logic [7:0] SLEEP_VEC  = 8'h2A;
    localparam logic [7:0] ERR_CLEAR  = 8'hFF;

    function automatic logic vec_is_valid(input logic [7:0] v);
        pmu_vec_t f;
        f = pmu_vec_t'(v);
        return (f.clock1 != ClkSrcInvalid) && (f.clock2 != ClkSrcInvalid) &&
               (f.clock3 != ClkSrcInvalid) && (f.div_sel != DivInvalid);
    endfunction

endpackage

// File: rtl/pmu_idle_timer.sv
// Inactivity timer: a seconds prescaler feeding a seconds counter. Fires a single expire
// pulse after IdleSecs quiet seconds, then holds until activity reloads it.
module pmu_idle_timer #(
    parameter int unsigned TicksPerSec = 12000000,
    parameter int unsigned IdleSecs    = 20
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic activity_i,
    output logic expire_o
);

    localparam int unsigned PreW = (TicksPerSec > 1) ? $clog2(TicksPerSec) : 1;
    localparam int unsigned SecW = (IdleSecs > 1) ? $clog2(IdleSecs) : 1;
    localparam logic [PreW-1:0] PreMax = PreW'(TicksPerSec - 1);
    localparam logic [SecW-1:0] SecMax = SecW'(IdleSecs - 1);

    logic [PreW-1:0] pre_q, pre_d;
    logic [SecW-1:0] sec_q, sec_d;
    logic            done_q, done_d;
    logic            pre_wrap, sec_last;

    assign pre_wrap = (pre_q == PreMax);
    assign sec_last = (sec_q == SecMax);
    // Activity in the same cycle suppresses expiry.
    assign expire_o = !done_q && !activity_i && pre_wrap && sec_last;

    always_comb begin
        pre_d  = pre_q;
        sec_d  = sec_q;
        done_d = done_q;
        if (activity_i) begin
            pre_d  = '0;
            sec_d  = '0;
            done_d = 1'b0;
        end else if (!done_q) begin
            if (pre_wrap) begin
                pre_d = '0;
                if (sec_last) begin
                    done_d = 1'b1;
                end else begin
                    sec_d = sec_q + 1'b1;
                end
            end else begin
                pre_d = pre_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            pre_q  <= '0;
            sec_q  <= '0;
            done_q <= 1'b0;
        end else begin
            pre_q  <= pre_d;
            sec_q  <= sec_d;
            done_q <= done_d;
        end
    end

endmodule

// File: rtl/pmu_request_ctrl.sv
// CPU-port mode requests to the power manager over a four-phase change/change_ack handshake.
// Define PMU_AUTO_SLEEP_EN to add idle-timer driven auto sleep and wake-on-activity.
module pmu_request_ctrl
    import pmu_pkg::*;
#(
    parameter int unsigned TICKS_PER_SEC = 12000000,
    parameter int unsigned IDLE_SECS     = 20,
    parameter logic [7:0]  PORT_ADDR     = 8'hF0,
    parameter int unsigned ACK_TIMEOUT   = 255
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       io_wr,
    input  logic [7:0] io_addr,
    input  logic [7:0] io_data,
    input  logic       activity,
    input  logic       change_ack,
    output logic       change,
    output logic [7:0] change_vector,
    output logic [7:0] cur_mode,
    output logic       busy,
    output logic       err
);

    localparam int unsigned CntW = $clog2(ACK_TIMEOUT + 1);
    localparam logic [CntW-1:0] CntMax = CntW'(ACK_TIMEOUT - 1);

    pmu_state_e      state_q;
    logic            change_q, busy_q, err_q;
    logic [7:0]      vec_q, cur_mode_q, pend_vec_q;
    logic            pend_valid_q;
    logic [CntW-1:0] cnt_q;

    logic       wr_hit, wr_clear, wr_bad, wr_ok;
    logic       auto_valid;
    logic [7:0] auto_vec;
    logic       new_valid, cand_valid, timeout;
    logic [7:0] new_vec, cand_vec;

    assign wr_hit   = io_wr && (io_addr == PORT_ADDR);
    assign wr_clear = wr_hit && (io_data == ERR_CLEAR);
    assign wr_bad   = wr_hit && !wr_clear && !vec_is_valid(io_data);
    assign wr_ok    = wr_hit && !wr_clear && vec_is_valid(io_data);

`ifdef PMU_AUTO_SLEEP_EN
    logic       expire, wake_req, sleep_req;
    logic [7:0] wake_q;

    pmu_idle_timer #(
        .TicksPerSec (TICKS_PER_SEC),
        .IdleSecs    (IDLE_SECS)
    ) u_idle_timer (
        .clk_i      (clk),
        .rst_ni     (reset),
        .activity_i (activity),
        .expire_o   (expire)
    );

    assign wake_req   = activity && (cur_mode_q == SLEEP_VEC);
    assign sleep_req  = expire && (cur_mode_q != SLEEP_VEC);
    assign auto_valid = (wake_req || sleep_req) && !wr_hit;
    assign auto_vec   = wake_req ? wake_q : SLEEP_VEC;

    always_ff @(posedge clk) begin
        if (!reset) begin
            wake_q <= RESET_MODE;
        end else if (sleep_req && !wr_hit) begin
            wake_q <= cur_mode_q;
        end
    end
`else
    logic unused_activity;
    assign unused_activity = ^{activity, 32'(TICKS_PER_SEC), 32'(IDLE_SECS)};
    assign auto_valid      = 1'b0;
    assign auto_vec        = 8'h00;
`endif

    assign new_valid = wr_ok || auto_valid;
    assign new_vec   = wr_ok ? io_data : auto_vec;
    // A fresh request bypasses the buffer so IDLE can issue it on the very next edge.
    assign cand_valid = new_valid || pend_valid_q;
    assign cand_vec   = new_valid ? new_vec : pend_vec_q;
    assign timeout    = (state_q == StReq) && !change_ack && (cnt_q == CntMax);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= StIdle;
            change_q     <= 1'b0;
            vec_q        <= 8'h00;
            cur_mode_q   <= RESET_MODE;
            busy_q       <= 1'b0;
            err_q        <= 1'b0;
            pend_valid_q <= 1'b0;
            pend_vec_q   <= 8'h00;
            cnt_q        <= '0;
        end else begin
            if (wr_bad || timeout) begin
                err_q <= 1'b1;
            end else if (wr_clear) begin
                err_q <= 1'b0;
            end
            if ((state_q != StIdle) && new_valid) begin
                pend_valid_q <= 1'b1;
                pend_vec_q   <= new_vec;
            end
            unique case (state_q)
                StIdle: begin
                    // The candidate is consumed here whether issued or discarded as redundant.
                    pend_valid_q <= 1'b0;
                    if (cand_valid && (cand_vec != cur_mode_q)) begin
                        state_q  <= StReq;
                        change_q <= 1'b1;
                        vec_q    <= cand_vec;
                        busy_q   <= 1'b1;
                        cnt_q    <= '0;
                    end
                end
                StReq: begin
                    if (change_ack) begin
                        state_q    <= StDone;
                        change_q   <= 1'b0;
                        cur_mode_q <= vec_q;
                    end else if (timeout) begin
                        state_q  <= StIdle;
                        change_q <= 1'b0;
                        busy_q   <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                StDone: begin
                    if (!change_ack) begin
                        state_q <= StIdle;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q  <= StIdle;
                    change_q <= 1'b0;
                    busy_q   <= 1'b0;
                end
            endcase
        end
    end

    assign change        = change_q;
    assign change_vector = vec_q;
    assign cur_mode      = cur_mode_q;
    assign busy          = busy_q;
    assign err           = err_q;

endmodule

// File: tb/tb_pmu_request_ctrl.sv
// Self-checking bench for pmu_request_ctrl; define PMU_AUTO_SLEEP_EN to exercise auto sleep.
module tb_pmu_request_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       io_wr = 1'b0;
    logic [7:0] io_addr = 8'h00;
    logic [7:0] io_data = 8'h00;
    logic       activity = 1'b0;
    logic       change_ack = 1'b0;
    logic       change, busy, err;
    logic [7:0] change_vector, cur_mode;

    int checks = 0;
    int errors = 0;

`ifdef PMU_AUTO_SLEEP_EN
    // Keeps the idle timer reloaded except while the sleep scenario runs.
    bit act_hold  = 1'b1;
    bit act_level = 1'b1;
`else
    bit act_hold  = 1'b0;
    bit act_level = 1'b0;
`endif

    pmu_request_ctrl #(
        .TICKS_PER_SEC (4),
        .IDLE_SECS     (2),
        .PORT_ADDR     (8'hF0),
        .ACK_TIMEOUT   (255)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .io_wr         (io_wr),
        .io_addr       (io_addr),
        .io_data       (io_data),
        .activity      (activity),
        .change_ack    (change_ack),
        .change        (change),
        .change_vector (change_vector),
        .cur_mode      (cur_mode),
        .busy          (busy),
        .err           (err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        activity = act_hold ? act_level : 1'($urandom_range(0, 1));
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset      = 1'b0;
        io_wr      = 1'b0;
        change_ack = 1'b0;
        tick();
        tick();
        reset = 1'b1;
    endtask

    task automatic cpu_write(input logic [7:0] addr, input logic [7:0] data);
        io_wr   = 1'b1;
        io_addr = addr;
        io_data = data;
        tick();
        io_wr = 1'b0;
    endtask

    function automatic bit has_invalid_field(input logic [7:0] v);
        for (int i = 0; i < 4; i++) begin
            if (((v >> (2 * i)) & 8'h03) == 8'h03) return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic test_reset();
        do_reset();
        checks++; if (change !== 1'b0) begin errors++; $display("FAIL reset_change: got %b want 0", change); end
        checks++; if (change_vector !== 8'h00) begin errors++; $display("FAIL reset_vector: got %h want 00", change_vector); end
        checks++; if (cur_mode !== 8'h20) begin errors++; $display("FAIL reset_cur_mode: got %h want 20", cur_mode); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", err); end
    endtask

    task automatic test_basic();
        do_reset();
        cpu_write(8'hF0, 8'h01);
        checks++; if (change !== 1'b1) begin errors++; $display("FAIL basic_change: got %b want 1", change); end
        checks++; if (change_vector !== 8'h01) begin errors++; $display("FAIL basic_vector: got %h want 01", change_vector); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy: got %b want 1", busy); end
        change_ack = 1'b1;
        tick();
        checks++; if (cur_mode !== 8'h01) begin errors++; $display("FAIL basic_cur_mode: got %h want 01", cur_mode); end
        checks++; if (change !== 1'b0) begin errors++; $display("FAIL basic_change_drop: got %b want 0", change); end
        change_ack = 1'b0;
        tick();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_idle: got %b want 0", busy); end
        // Same mode again is silently discarded; a write to another port is ignored.
        cpu_write(8'hF0, 8'h01);
        checks++; if (change !== 1'b0) begin errors++; $display("FAIL same_mode: got %b want 0", change); end
        cpu_write(8'hF1, 8'h02);
        checks++; if (change !== 1'b0) begin errors++; $display("FAIL wrong_addr: got %b want 0", change); end
    endtask

    task automatic test_invalid();
        do_reset();
        cpu_write(8'hF0, 8'h03);
        checks++; if (change !== 1'b0) begin errors++; $display("FAIL invalid_change: got %b want 0", change); end
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL invalid_err: got %b want 1", err); end
        cpu_write(8'hF0, 8'hFF);
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL clear_err: got %b want 0", err); end
        checks++; if (change !== 1'b0) begin errors++; $display("FAIL clear_no_req: got %b want 0", change); end
        cpu_write(8'hF0, 8'hC0);
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL div_invalid_err: got %b want 1", err); end
        cpu_write(8'hF0, 8'hFF);
    endtask

    task automatic test_timeout();
        int n;
        do_reset();
        cpu_write(8'hF0, 8'h01);
        n = (change === 1'b1) ? 1 : 0;
        while (change === 1'b1 && n < 400) begin
            tick();
            if (change === 1'b1) n++;
        end
        checks++; if (n != 255) begin errors++; $display("FAIL timeout_cycles: got %0d want 255", n); end
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL timeout_err: got %b want 1", err); end
        checks++; if (cur_mode !== 8'h20) begin errors++; $display("FAIL timeout_cur_mode: got %h want 20", cur_mode); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL timeout_busy: got %b want 0", busy); end
    endtask

    task automatic test_back_to_back();
        int seen;
        do_reset();
        cpu_write(8'hF0, 8'h01);
        cpu_write(8'hF0, 8'h04);
        cpu_write(8'hF0, 8'h10);
        change_ack = 1'b1;
        tick();
        change_ack = 1'b0;
        tick();
        tick();
        checks++; if (change !== 1'b1) begin errors++; $display("FAIL b2b_change: got %b want 1", change); end
        checks++; if (change_vector !== 8'h10) begin errors++; $display("FAIL b2b_vector: got %h want 10", change_vector); end
        change_ack = 1'b1;
        tick();
        change_ack = 1'b0;
        tick();
        checks++; if (cur_mode !== 8'h10) begin errors++; $display("FAIL b2b_cur_mode: got %h want 10", cur_mode); end
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (change === 1'b1) seen++;
        end
        checks++; if (seen != 0) begin errors++; $display("FAIL b2b_stale: got %0d want 0", seen); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        cpu_write(8'hF0, 8'h05);
        reset = 1'b0;
        tick();
        checks++; if (change !== 1'b0) begin errors++; $display("FAIL midrst_change: got %b want 0", change); end
        checks++; if (change_vector !== 8'h00) begin errors++; $display("FAIL midrst_vector: got %h want 00", change_vector); end
        checks++; if (cur_mode !== 8'h20) begin errors++; $display("FAIL midrst_cur_mode: got %h want 20", cur_mode); end
        checks++; if (busy !== 1'b0 || err !== 1'b0) begin errors++; $display("FAIL midrst_flags: got busy=%b err=%b want 0 0", busy, err); end
        reset = 1'b1;
    endtask

    task automatic test_random();
        logic [7:0] d, model_cur;
        bit         model_err, exp_change;
        int         wait_n;
        do_reset();
        model_cur = 8'h20;
        model_err = 1'b0;
        for (int it = 0; it < 30; it++) begin
            if ($urandom_range(0, 1) == 0) begin
                d = 8'($urandom_range(0, 255));
            end else begin
                d = {2'($urandom_range(0, 2)), 2'($urandom_range(0, 2)),
                     2'($urandom_range(0, 2)), 2'($urandom_range(0, 2))};
            end
            if (d == 8'h2A) d = 8'h2B;
            cpu_write(8'hF0, d);
            exp_change = 1'b0;
            if (d == 8'hFF) model_err = 1'b0;
            else if (has_invalid_field(d)) model_err = 1'b1;
            else if (d != model_cur) exp_change = 1'b1;
            checks++; if (change !== exp_change) begin errors++; $display("FAIL rand_change[%0d] d=%h: got %b want %b", it, d, change, exp_change); end
            checks++; if (err !== model_err) begin errors++; $display("FAIL rand_err[%0d] d=%h: got %b want %b", it, d, err, model_err); end
            if (exp_change) begin
                wait_n = $urandom_range(0, 4);
                repeat (wait_n) tick();
                checks++; if (change !== 1'b1 || change_vector !== d) begin errors++; $display("FAIL rand_hold[%0d]: got %b/%h want 1/%h", it, change, change_vector, d); end
                change_ack = 1'b1;
                tick();
                model_cur = d;
                change_ack = 1'b0;
                tick();
                checks++; if (cur_mode !== model_cur || busy !== 1'b0) begin errors++; $display("FAIL rand_done[%0d]: got %h/%b want %h/0", it, cur_mode, busy, model_cur); end
            end
        end
    endtask

`ifdef PMU_AUTO_SLEEP_EN
    task automatic test_auto_sleep();
        int n;
        act_level = 1'b0;
        do_reset();
        n = 0;
        while (change !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        checks++; if (n < 7 || n > 9) begin errors++; $display("FAIL sleep_delay: got %0d want 8", n); end
        checks++; if (change_vector !== 8'h2A) begin errors++; $display("FAIL sleep_vector: got %h want 2a", change_vector); end
        change_ack = 1'b1;
        tick();
        change_ack = 1'b0;
        tick();
        checks++; if (cur_mode !== 8'h2A) begin errors++; $display("FAIL sleep_cur_mode: got %h want 2a", cur_mode); end
        act_level = 1'b1;
        tick();
        act_level = 1'b0;
        checks++; if (change !== 1'b1 || change_vector !== 8'h20) begin errors++; $display("FAIL wake_req: got %b/%h want 1/20", change, change_vector); end
        change_ack = 1'b1;
        act_level  = 1'b1;
        tick();
        change_ack = 1'b0;
        tick();
        checks++; if (cur_mode !== 8'h20) begin errors++; $display("FAIL wake_cur_mode: got %h want 20", cur_mode); end
    endtask
`else
    task automatic test_activity_ignored();
        int seen;
        do_reset();
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (change === 1'b1 || busy === 1'b1) seen++;
        end
        checks++; if (seen != 0) begin errors++; $display("FAIL activity_ignored: got %0d want 0", seen); end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_invalid();
        test_timeout();
        test_back_to_back();
        test_reset_mid();
        test_random();
`ifdef PMU_AUTO_SLEEP_EN
        test_auto_sleep();
`else
        test_activity_ignored();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
